// File: rtl/scanline_irq_ctrl_pkg.sv
// rtl/scanline_irq_ctrl_pkg.sv - shared mapper constants for the scanline IRQ block
package scanline_irq_ctrl_pkg;

  // Mapper register select encodings for the scanline IRQ register group
  typedef enum logic [1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

  // A12 rising-edge filter states
  typedef enum logic [1:0] {
    LOW_WAIT = 2'd0,
    ARMED    = 2'd1,
    HIGH     = 2'd2
  } a12_state_e;

  localparam int A12_LOW_MIN_DEFAULT = 3;
  localparam int COUNTER_W           = 8;

endpackage

// File: rtl/scanline_irq_ctrl_if.sv
// rtl/scanline_irq_ctrl_if.sv - mapper register write bus into the scanline IRQ block
interface scanline_irq_ctrl_if;
  import scanline_irq_ctrl_pkg::*;

  logic                 reg_wr;
  logic [1:0]           reg_sel;
  logic [COUNTER_W-1:0] reg_data;

  modport master (
    output reg_wr,
    output reg_sel,
    output reg_data
  );

  modport slave (
    input reg_wr,
    input reg_sel,
    input reg_data
  );

endinterface

// File: rtl/scanline_irq_ctrl_a12_edge_filter.sv
// rtl/scanline_irq_ctrl_a12_edge_filter.sv - A12 synchronizer and low-time-qualified rise detector
module a12_edge_filter
  import scanline_irq_ctrl_pkg::*;
#(
  parameter int A12_LOW_MIN = A12_LOW_MIN_DEFAULT
) (
  input  logic m2,
  input  logic reset_n,
  input  logic ppu_a12,
  output logic clk_event
);

  localparam int CW = (A12_LOW_MIN < 2) ? 1 : $clog2(A12_LOW_MIN + 1);

  logic          a12_s1;
  logic          a12_s2;
  a12_state_e    state;
  logic [CW-1:0] low_cnt;

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      a12_s1    <= 1'b0;
      a12_s2    <= 1'b0;
      state     <= LOW_WAIT;
      low_cnt   <= '0;
      clk_event <= 1'b0;
    end else begin
      a12_s1    <= ppu_a12;
      a12_s2    <= a12_s1;
      clk_event <= 1'b0;
      case (state)
        LOW_WAIT: begin
          if (a12_s2) begin
            state <= HIGH;
          end else begin
            if (int'(low_cnt) < A12_LOW_MIN) begin
              low_cnt <= low_cnt + CW'(1);
            end
            if (int'(low_cnt) + 1 >= A12_LOW_MIN) begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (a12_s2) begin
            state     <= HIGH;
            clk_event <= 1'b1;
          end
        end
        HIGH: begin
          // The falling sample itself is the first qualifying low cycle
          if (!a12_s2) begin
            low_cnt <= CW'(1);
            state   <= (A12_LOW_MIN <= 1) ? ARMED : LOW_WAIT;
          end
        end
        default: begin
          state   <= LOW_WAIT;
          low_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/scanline_irq_ctrl.sv
// rtl/scanline_irq_ctrl.sv - scanline counter and IRQ register block driven by filtered A12 rises
module scanline_irq_ctrl
  import scanline_irq_ctrl_pkg::*;
#(
  parameter int A12_LOW_MIN      = A12_LOW_MIN_DEFAULT,
  parameter bit REV_A            = 1'b0,
  parameter bit USE_SCANLINE_IRQ = 1'b1
) (
  input  logic                  m2,
  input  logic                  reset_n,
  input  logic                  ppu_a12,
  scanline_irq_ctrl_if.slave    bus,
  output logic                  irq,
  output logic [COUNTER_W-1:0]  counter_q
);

  generate
    if (USE_SCANLINE_IRQ) begin : g_irq
      logic                 clk_event;
      logic [COUNTER_W-1:0] latch;
      logic [COUNTER_W-1:0] counter;
      logic                 reload_flag;
      logic                 enabled;
      logic                 pending;
      logic                 irq_n;

      logic [COUNTER_W-1:0] latch_nxt;
      logic [COUNTER_W-1:0] counter_nxt;
      logic [COUNTER_W-1:0] ev_cnt;
      logic                 reload_flag_nxt;
      logic                 enabled_nxt;
      logic                 pending_nxt;

      a12_edge_filter #(
        .A12_LOW_MIN (A12_LOW_MIN)
      ) u_filter (
        .m2        (m2),
        .reset_n   (reset_n),
        .ppu_a12   (ppu_a12),
        .clk_event (clk_event)
      );

      // Event is evaluated on pre-write state, then the register write lands on top
      always_comb begin
        latch_nxt       = latch;
        counter_nxt     = counter;
        ev_cnt          = counter;
        reload_flag_nxt = reload_flag;
        enabled_nxt     = enabled;
        pending_nxt     = pending;

        if (clk_event) begin
          if ((counter == '0) || reload_flag) begin
            ev_cnt          = latch;
            reload_flag_nxt = 1'b0;
          end else begin
            ev_cnt = counter - COUNTER_W'(1);
          end
          counter_nxt = ev_cnt;
          if ((ev_cnt == '0) && enabled &&
              (!REV_A || (counter != '0) || reload_flag)) begin
            pending_nxt = 1'b1;
          end
        end

        if (bus.reg_wr) begin
          case (reg_sel_e'(bus.reg_sel))
            REG_LATCH: begin
              latch_nxt = bus.reg_data;
            end
            REG_RELOAD: begin
              // A coincident event keeps its counter result; the flag forces the next load
              reload_flag_nxt = 1'b1;
              if (!clk_event) begin
                counter_nxt = '0;
              end
            end
            REG_DISABLE: begin
              enabled_nxt = 1'b0;
              pending_nxt = 1'b0;
            end
            REG_ENABLE: begin
              enabled_nxt = 1'b1;
            end
            default: begin
              enabled_nxt = enabled;
            end
          endcase
        end
      end

      always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
          latch       <= '0;
          counter     <= '0;
          reload_flag <= 1'b0;
          enabled     <= 1'b0;
          pending     <= 1'b0;
          irq_n       <= 1'b1;
        end else begin
          latch       <= latch_nxt;
          counter     <= counter_nxt;
          reload_flag <= reload_flag_nxt;
          enabled     <= enabled_nxt;
          pending     <= pending_nxt;
          irq_n       <= ~pending_nxt;
        end
      end

      assign irq       = irq_n;
      assign counter_q = counter;
    end else begin : g_none
      assign irq       = 1'b1;
      assign counter_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_scanline_irq_ctrl.sv
// tb/tb_scanline_irq_ctrl.sv - directed bench for scanline_irq_ctrl
module tb_scanline_irq_ctrl;
  import scanline_irq_ctrl_pkg::*;

  logic       m2      = 1'b0;
  logic       reset_n = 1'b1;
  logic       ppu_a12 = 1'b0;
  logic       irq0, irq1;
  logic [7:0] cnt0, cnt1;

  scanline_irq_ctrl_if bus ();

  scanline_irq_ctrl #(.A12_LOW_MIN(3), .REV_A(1'b0), .USE_SCANLINE_IRQ(1'b1)) u_dut0 (
    .m2(m2), .reset_n(reset_n), .ppu_a12(ppu_a12), .bus(bus), .irq(irq0), .counter_q(cnt0)
  );

  scanline_irq_ctrl #(.A12_LOW_MIN(3), .REV_A(1'b1), .USE_SCANLINE_IRQ(1'b1)) u_dut1 (
    .m2(m2), .reset_n(reset_n), .ppu_a12(ppu_a12), .bus(bus), .irq(irq1), .counter_q(cnt1)
  );

  always #5 m2 = ~m2;

  int checks = 0;
  int passes = 0;

  typedef struct {
    bit         wr;
    logic [1:0] sel;
    logic [7:0] data;
    bit         ev;
    logic [7:0] exp_cnt;
    logic       exp_irq;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [7:0] data);
    @(negedge m2);
    bus.reg_wr   = 1'b1;
    bus.reg_sel  = sel;
    bus.reg_data = data;
    @(negedge m2);
    bus.reg_wr   = 1'b0;
  endtask

  // Low for 'lows' cycles, then rise; optional write lands in the event cycle
  task automatic a12_event(input int lows, input bit wr, input logic [1:0] sel, input logic [7:0] data);
    @(negedge m2);
    ppu_a12 = 1'b0;
    repeat (lows) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (3) @(negedge m2);
    if (wr) begin
      bus.reg_wr   = 1'b1;
      bus.reg_sel  = sel;
      bus.reg_data = data;
    end
    @(negedge m2);
    bus.reg_wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge m2);
    reset_n = 1'b0;
    repeat (2) @(negedge m2);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.reg_wr   = 1'b0;
    bus.reg_sel  = 2'd0;
    bus.reg_data = 8'd0;

    vecs[0]  = '{1'b1, REG_LATCH,   8'd3,   1'b0, 8'd0,   1'b1};
    vecs[1]  = '{1'b1, REG_RELOAD,  8'd0,   1'b0, 8'd0,   1'b1};
    vecs[2]  = '{1'b1, REG_ENABLE,  8'd0,   1'b0, 8'd0,   1'b1};
    vecs[3]  = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd3,   1'b1};
    vecs[4]  = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd2,   1'b1};
    vecs[5]  = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd1,   1'b1};
    vecs[6]  = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd0,   1'b0};
    vecs[7]  = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd3,   1'b0};
    vecs[8]  = '{1'b1, REG_DISABLE, 8'd0,   1'b0, 8'd3,   1'b1};
    vecs[9]  = '{1'b1, REG_ENABLE,  8'd0,   1'b0, 8'd3,   1'b1};
    vecs[10] = '{1'b1, REG_LATCH,   8'h10,  1'b0, 8'd3,   1'b1};
    vecs[11] = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'd2,   1'b1};
    vecs[12] = '{1'b1, REG_RELOAD,  8'd0,   1'b0, 8'd0,   1'b1};
    vecs[13] = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'h10,  1'b1};
    vecs[14] = '{1'b0, REG_LATCH,   8'd0,   1'b1, 8'h0f,  1'b1};

    #1 reset_n = 1'b0;
    #1;
    check("reset_irq", {7'd0, irq0}, 8'd1);
    check("reset_cnt", cnt0, 8'd0);
    repeat (2) @(negedge m2);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].sel, vecs[i].data);
      if (vecs[i].ev) a12_event(5, 1'b0, 2'd0, 8'd0);
      check($sformatf("vec%0d_cnt", i), cnt0, vecs[i].exp_cnt);
      check($sformatf("vec%0d_irq", i), {7'd0, irq0}, {7'd0, vecs[i].exp_irq});
    end

    // Too-short low phase is ignored, a qualified one counts
    a12_event(2, 1'b0, 2'd0, 8'd0);
    check("short_low_cnt", cnt0, 8'h0f);
    a12_event(3, 1'b0, 2'd0, 8'd0);
    check("min_low_cnt", cnt0, 8'h0e);

    // Reload write coincident with an event
    wr_reg(REG_LATCH, 8'd5);
    wr_reg(REG_RELOAD, 8'd0);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("reload5_cnt", cnt0, 8'd5);
    wr_reg(REG_LATCH, 8'd7);
    a12_event(5, 1'b1, REG_RELOAD, 8'd0);
    check("reload_coinc_cnt", cnt0, 8'd4);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("reload_flag_load", cnt0, 8'd7);

    // Disable write coincident with the event that reaches zero
    wr_reg(REG_LATCH, 8'd1);
    wr_reg(REG_RELOAD, 8'd0);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("pre_zero_cnt", cnt0, 8'd1);
    a12_event(5, 1'b1, REG_DISABLE, 8'd0);
    check("dis_coinc_cnt", cnt0, 8'd0);
    check("dis_coinc_irq", {7'd0, irq0}, 8'd1);
    repeat (2) @(negedge m2);
    check("dis_coinc_irq_late", {7'd0, irq0}, 8'd1);

    // Latch = 0: REV_A 0 fires every event, REV_A 1 only after reload
    pulse_reset();
    wr_reg(REG_LATCH, 8'd0);
    wr_reg(REG_ENABLE, 8'd0);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("l0_ev1_irq0", {7'd0, irq0}, 8'd0);
    check("l0_ev1_irq1", {7'd0, irq1}, 8'd1);
    wr_reg(REG_DISABLE, 8'd0);
    check("l0_dis_irq0", {7'd0, irq0}, 8'd1);
    wr_reg(REG_ENABLE, 8'd0);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("l0_ev2_irq0", {7'd0, irq0}, 8'd0);
    check("l0_ev2_irq1", {7'd0, irq1}, 8'd1);
    wr_reg(REG_RELOAD, 8'd0);
    a12_event(5, 1'b0, 2'd0, 8'd0);
    check("l0_reload_irq1", {7'd0, irq1}, 8'd0);
    check("l0_cnt1", cnt1, 8'd0);

    // Asynchronous reset mid-HIGH with IRQ pending
    @(negedge m2);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irq0", {7'd0, irq0}, 8'd1);
    check("async_rst_irq1", {7'd0, irq1}, 8'd1);
    check("async_rst_cnt", cnt0, 8'd0);
    repeat (3) @(negedge m2);
    reset_n = 1'b1;
    wr_reg(REG_LATCH, 8'd9);
    repeat (4) @(negedge m2);
    check("no_event_on_release", cnt0, 8'd0);
    a12_event(3, 1'b0, 2'd0, 8'd0);
    check("post_rst_event_cnt", cnt0, 8'd9);
    check("post_rst_irq", {7'd0, irq0}, 8'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
